// File: rtl/fourbyone_arbiter_if.sv
// ---------------------------------------------------------------------------
// fourbyone_arbiter_if
//   Bundle of the four requester ports, the shared output word and its
//   valid/ready handshake.
//
//   Parameter:
//     n          data width of A..D and Y
//   Signals:
//     req[3:0]   request per port (bit0=A .. bit3=D)
//     A,B,C,D    requester data words
//     out_ready  downstream accepts Y when high together with out_valid
//     S[1:0]     registered select of the current/last winner
//     gnt[3:0]   one-hot, single-cycle grant pulse
//     Y          registered selected word
//     out_valid  Y holds a word not yet accepted
//   Modports:
//     master     producer/consumer side (drives req, data, out_ready)
//     slave      arbiter side (drives S, gnt, Y, out_valid)
// ---------------------------------------------------------------------------
interface fourbyone_arbiter_if #(
  parameter int n = 4
);
  logic [3:0]   req;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] C;
  logic [n-1:0] D;
  logic         out_ready;
  logic [1:0]   S;
  logic [3:0]   gnt;
  logic [n-1:0] Y;
  logic         out_valid;

  modport master (
    output req, A, B, C, D, out_ready,
    input  S, gnt, Y, out_valid
  );

  modport slave (
    input  req, A, B, C, D, out_ready,
    output S, gnt, Y, out_valid
  );
endinterface

// File: rtl/fourbyone_arbiter.sv
// ---------------------------------------------------------------------------
// fourbyone_arbiter
//   Round-robin arbiter plus registered output stage sharing one n-bit 4:1
//   mux among requesters A..D. The winner's word is captured into Y and held
//   under a valid/ready handshake until the consumer accepts it. When the
//   consumer accepts and another request is pending, the next word is
//   captured in the same edge, so one word per cycle is sustainable.
//
//   Ports:
//     clk   system clock, all state updates on the rising edge
//     rst   synchronous, active-high reset
//     bus   fourbyone_arbiter_if.slave (req, A..D, out_ready in;
//           S, gnt, Y, out_valid out)
//
//   Configuration macro:
//     FOURBYONE_ARB_FIXED_PRIO_EN  when defined, fixed priority A>B>C>D
//                                  replaces the round-robin search. The
//                                  last-grant pointer is still maintained.
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fourbyone_arbiter #(
  parameter int n = 4
) (
  input  logic               clk,
  input  logic               rst,
  fourbyone_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state_reg;
  logic [1:0]   ptr_reg;        // index of the last winner
  logic [1:0]   s_reg;
  logic [3:0]   gnt_reg;
  logic [n-1:0] y_reg;
  logic         out_valid_reg;

  logic [3:0]   eff_req;
  logic         win_found;
  logic [1:0]   win_idx;
  logic [3:0]   win_onehot;
  logic [n-1:0] words [4];
  logic [n-1:0] win_word;

  // A requester sees its grant pulse one cycle late and only then drops
  // req; masking the currently granted bit keeps that stale request from
  // winning a second time.
  assign eff_req = bus.req & ~gnt_reg;

  assign words[0] = bus.A;
  assign words[1] = bus.B;
  assign words[2] = bus.C;
  assign words[3] = bus.D;

  assign win_word = words[win_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 2'(gi));
    end
  endgenerate

`ifdef FOURBYONE_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from D down to A so the lowest index is the last
  // assignment and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (eff_req[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end
`else
  // Round-robin: candidates in search order are ptr+1, ptr+2, ptr+3, ptr
  // (all mod 4). Scanning from the farthest candidate to the nearest lets
  // the nearest pending one overwrite the others.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = 2'b00;
    cand      = 2'b00;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_reg + 2'(i);
      if (eff_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Control FSM with registered outputs. gnt defaults to zero every cycle
  // so it is a single-cycle pulse aligned with the first cycle of a new Y.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'b11;     // A searched first after reset
      s_reg         <= 2'b00;
      gnt_reg       <= 4'b0000;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      gnt_reg <= 4'b0000;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            s_reg         <= win_idx;
            y_reg         <= win_word;
            gnt_reg       <= win_onehot;
            ptr_reg       <= win_idx;
            out_valid_reg <= 1'b1;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          // Without out_ready the held word, select and valid stay put and
          // new requests wait.
          if (bus.out_ready) begin
            if (win_found) begin
              s_reg         <= win_idx;
              y_reg         <= win_word;
              gnt_reg       <= win_onehot;
              ptr_reg       <= win_idx;
              out_valid_reg <= 1'b1;
            end else begin
              // S and Y keep the last delivered values.
              out_valid_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S         = s_reg;
  assign bus.gnt       = gnt_reg;
  assign bus.Y         = y_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_fourbyone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fourbyone_arbiter
//   Table of per-cycle vectors (inputs applied before a rising edge, outputs
//   expected right after it), followed by a short hand-written sequence that
//   checks outputs do not move between edges and a final back-to-back grant.
//   Expectations for the fixed-priority build are selected with the same
//   macro as the design.
// ---------------------------------------------------------------------------
module tb_fourbyone_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst;

  fourbyone_arbiter_if #(.n(N)) bus ();

  fourbyone_arbiter #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] b;
    logic       rdy;
    logic [1:0] es;
    logic [3:0] eg;
    logic [3:0] ey;
    logic       ev;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  // A, C and D stay at 1, A and 7; only B varies across the table.
  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] b,
                     input logic rdy, input logic [1:0] es, input logic [3:0] eg,
                     input logic [3:0] ey, input logic ev);
    vec_t v;
    v.rst = r; v.req = rq; v.b = b; v.rdy = rdy;
    v.es = es; v.eg = eg; v.ey = ey; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] es, input logic [3:0] eg,
                         input logic [3:0] ey, input logic ev);
    chk({tag, ".S"},         int'(bus.S),         int'(es));
    chk({tag, ".gnt"},       int'(bus.gnt),       int'(eg));
    chk({tag, ".Y"},         int'(bus.Y),         int'(ey));
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(ev));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req = 4'b0000;
    bus.A = 4'h1; bus.B = 4'h3; bus.C = 4'hA; bus.D = 4'h7;
    bus.out_ready = 1'b0;

    //   rst  req      B     rdy   S      gnt      Y     valid
    // reset held with every request pending
    add(1, 4'b1111, 4'h3, 1, 2'b00, 4'b0000, 4'h0, 0);   // 0
    add(1, 4'b1111, 4'h3, 1, 2'b00, 4'b0000, 4'h0, 0);   // 1
    // single request C, then dropped
    add(0, 4'b0100, 4'h3, 1, 2'b10, 4'b0100, 4'hA, 1);   // 2
    add(0, 4'b0000, 4'h3, 1, 2'b10, 4'b0000, 4'hA, 0);   // 3
    add(0, 4'b0000, 4'h3, 1, 2'b10, 4'b0000, 4'hA, 0);   // 4
    // reset, then rotation with all requests held
    add(1, 4'b0000, 4'h3, 1, 2'b00, 4'b0000, 4'h0, 0);   // 5
    add(0, 4'b1111, 4'h3, 1, 2'b00, 4'b0001, 4'h1, 1);   // 6
    add(0, 4'b1111, 4'h3, 1, 2'b01, 4'b0010, 4'h3, 1);   // 7
`ifdef FOURBYONE_ARB_FIXED_PRIO_EN
    add(0, 4'b1111, 4'h3, 1, 2'b00, 4'b0001, 4'h1, 1);   // 8
    add(0, 4'b1111, 4'h3, 1, 2'b01, 4'b0010, 4'h3, 1);   // 9
`else
    add(0, 4'b1111, 4'h3, 1, 2'b10, 4'b0100, 4'hA, 1);   // 8
    add(0, 4'b1111, 4'h3, 1, 2'b11, 4'b1000, 4'h7, 1);   // 9
`endif
    add(0, 4'b1111, 4'h3, 1, 2'b00, 4'b0001, 4'h1, 1);   // 10
    // backpressure on a B grant while B data and requests change
    add(0, 4'b0010, 4'h3, 1, 2'b01, 4'b0010, 4'h3, 1);   // 11
    add(0, 4'b1001, 4'hF, 0, 2'b01, 4'b0000, 4'h3, 1);   // 12
    add(0, 4'b1001, 4'hF, 0, 2'b01, 4'b0000, 4'h3, 1);   // 13
    add(0, 4'b1001, 4'hF, 0, 2'b01, 4'b0000, 4'h3, 1);   // 14
`ifdef FOURBYONE_ARB_FIXED_PRIO_EN
    add(0, 4'b1001, 4'hF, 1, 2'b00, 4'b0001, 4'h1, 1);   // 15
    add(0, 4'b0000, 4'hF, 0, 2'b00, 4'b0000, 4'h1, 1);   // 16
`else
    add(0, 4'b1001, 4'hF, 1, 2'b11, 4'b1000, 4'h7, 1);   // 15
    add(0, 4'b0000, 4'hF, 0, 2'b11, 4'b0000, 4'h7, 1);   // 16
`endif
    // reset discards the held word, then A first
    add(1, 4'b0000, 4'h3, 0, 2'b00, 4'b0000, 4'h0, 0);   // 17
    add(0, 4'b1111, 4'h3, 0, 2'b00, 4'b0001, 4'h1, 1);   // 18
    add(0, 4'b0000, 4'h3, 0, 2'b00, 4'b0000, 4'h1, 1);   // 19
    add(0, 4'b0000, 4'h3, 1, 2'b00, 4'b0000, 4'h1, 0);   // 20
    // a held req is masked during its own gnt cycle, then eligible again
    add(0, 4'b0100, 4'h3, 0, 2'b10, 4'b0100, 4'hA, 1);   // 21
    add(0, 4'b0100, 4'h3, 1, 2'b10, 4'b0000, 4'hA, 0);   // 22
    add(0, 4'b0100, 4'h3, 1, 2'b10, 4'b0100, 4'hA, 1);   // 23

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst           = vecs[k].rst;
      bus.req       = vecs[k].req;
      bus.B         = vecs[k].b;
      bus.out_ready = vecs[k].rdy;
      @(posedge clk);
      #1;
      $display("step %0d rst=%0b req=%b rdy=%0b -> S=%b gnt=%b Y=%h valid=%0b",
               k, vecs[k].rst, vecs[k].req, vecs[k].rdy,
               bus.S, bus.gnt, bus.Y, bus.out_valid);
      chk_all($sformatf("step%0d", k), vecs[k].es, vecs[k].eg, vecs[k].ey, vecs[k].ev);
    end

    // Outputs must not follow inputs between edges (state: C word held,
    // gnt pulse still high this cycle).
    @(negedge clk);
    bus.req = 4'b1111; bus.A = 4'hF; bus.C = 4'h5; bus.out_ready = 1'b0;
    #1;
    $display("midcycle req=1111 A=F C=5 -> S=%b gnt=%b Y=%h valid=%0b",
             bus.S, bus.gnt, bus.Y, bus.out_valid);
    chk_all("midcycle", 2'b10, 4'b0100, 4'hA, 1'b1);

    // Held under backpressure despite new data and requests.
    @(posedge clk);
    #1;
    $display("hold rdy=0 -> S=%b gnt=%b Y=%h valid=%0b",
             bus.S, bus.gnt, bus.Y, bus.out_valid);
    chk_all("hold", 2'b10, 4'b0000, 4'hA, 1'b1);

    // Accept and re-arbitrate in the same edge.
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("b2b rdy=1 req=1111 -> S=%b gnt=%b Y=%h valid=%0b",
             bus.S, bus.gnt, bus.Y, bus.out_valid);
`ifdef FOURBYONE_ARB_FIXED_PRIO_EN
    chk_all("b2b", 2'b00, 4'b0001, 4'hF, 1'b1);
`else
    chk_all("b2b", 2'b11, 4'b1000, 4'h7, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourbyone_arbiter.md
# fourbyone_arbiter

Round-robin arbiter and output stage that shares one n-bit 4x1 multiplexer path among four requesters (A–D). It picks one pending requester, drives the mux select, captures the selected word into an output register and holds it under a valid/ready handshake until the downstream consumer accepts it. It sits between four producer ports and a single shared downstream bus.

## Interface
- n, 4, data width of each input word and of Y
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req  input  4  request per port; req[0]=A, req[1]=B, req[2]=C, req[3]=D
- A, B, C, D  input  n  requester data words
- out_ready  input  1  downstream accepts Y when high with out_valid
- S  output  2  registered mux select of current/last winner (00=A, 01=B, 10=C, 11=D)
- gnt  output  4  one-hot grant pulse, high exactly one cycle after capture
- Y  output  n  registered selected word
- out_valid  output  1  Y holds an unaccepted word

## Operation
- One clock; reset is synchronous and active-high.
- Reset values: S=2'b00, gnt=4'b0000, Y=0, out_valid=0, state=IDLE, last-grant pointer=2'b11 (A highest priority first).
- States: IDLE (out_valid=0) and BUSY (out_valid=1).
- Effective requests: req with the bit of the currently high gnt masked off; requester drops req during its gnt cycle, so a held req is not re-granted immediately.
- Arbitration (round-robin): search starts at pointer+1 mod 4 and wraps (3 -> 0); first effective request wins.
- IDLE, any effective request: at the edge, S<=winner, Y<=word of winner, gnt<=onehot(winner), pointer<=winner, out_valid<=1, go to BUSY.
- IDLE, no request: all outputs hold, gnt<=0.
- BUSY, out_ready=0: Y, S, out_valid hold; gnt<=0; req ignored; input data changes do not affect Y.
- BUSY, out_ready=1: transfer completes. If an effective request exists, arbitrate as in IDLE in the same edge (back-to-back, stay BUSY). Otherwise out_valid<=0, gnt<=0, go to IDLE; S and Y retain last values.
- req arriving in the same cycle as out_ready in BUSY is eligible for that edge.
- rst wins over everything, including a mid-transfer word (discarded, not delivered).

## Timing
- Request-to-grant latency: 1 cycle (req sampled at edge k; gnt, S, Y, out_valid valid during cycle k+1).
- gnt is a single-cycle pulse, coincident with the first cycle of the new Y.
- Peak throughput: one word per cycle with out_ready held high and requests pending.
- Y is stable from the capture edge until the edge where out_valid&out_ready is sampled.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- Macro FOURBYONE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority A>B>C>D; pointer is not used for the search (still updated, unobservable). Masking of the currently granted bit still applies.
- Undefined (default): round-robin as described.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> S=00, gnt=0000, Y=0, out_valid=0; no grant while rst high.
- Single request: n=4, req=4'b0100, C=4'hA, out_ready=1 -> next cycle gnt=0100, S=10, Y=4'hA, out_valid=1; req dropped -> following cycle out_valid=0, gnt=0000.
- Round-robin rotation: req=4'b1111 held, out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, Y tracking A, B, C, D.
- Backpressure: grant B with B=4'h3, out_ready=0 for 3 cycles while B changes to 4'hF and req=4'b1001 -> Y=4'h3, S=01, gnt=0000 throughout; out_ready=1 -> next cycle gnt=1000 (D after B), S=11.
- Reset mid-transfer: out_valid=1, out_ready=0, rst=1 one cycle -> out_valid=0, Y=0, S=00; then req=4'b1111 -> first grant 0001.
- With FOURBYONE_ARB_FIXED_PRIO_EN, req=4'b1111 held, out_ready=1 -> gnt alternates 0001, 0010, 0001, 0010; C and D never granted.
